hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 44 ++++
 rtl/hazard_forward_unit_track_entry.sv | 36 +++
 rtl/hazard_forward_unit.sv | 116 +++++++++++
 tb/tb_hazard_forward_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// +--------------------------------------------------------------------+
// | hazard_forward_unit_pkg: forward-select codes and tracked entry.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package hazard_forward_unit_pkg;

  // Shared with the EX-stage operand selectors.
  localparam logic [1:0] FORWARD_NONE = 2'b00;
  localparam logic [1:0] FORWARD_WB   = 2'b01;
  localparam logic [1:0] FORWARD_MEM  = 2'b10;
  localparam logic [4:0] REG_0_ADDR   = 5'd0;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       is_load;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } entry_t;

  localparam entry_t ENTRY_EMPTY = '0;

  // The younger MEM result wins; a load in MEM has no data yet.
  function automatic logic [1:0] fwd_sel(input entry_t mem, input entry_t wb,
                                         input logic [4:0] src, input logic uses);
    logic [1:0] sel;
    sel = FORWARD_NONE;
    if (uses && (src != REG_0_ADDR)) begin
      if (mem.valid && mem.reg_write && !mem.is_load && (mem.dst == src))
        sel = FORWARD_MEM;
      else if (wb.valid && wb.reg_write && (wb.dst == src))
        sel = FORWARD_WB;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_forward_unit_track_entry.sv
// +--------------------------------------------------------------------+
// | hazard_track_entry: one pipeline-stage record with load/clear/hold.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_track_entry
  import hazard_forward_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_hold,
  input  logic   i_clear,
  input  logic   i_load,
  input  entry_t i_entry,
  output entry_t o_entry
);

  entry_t r_entry;

  always_ff @(posedge clk) begin
    if (rst)
      r_entry <= ENTRY_EMPTY;
    else if (i_hold)
      r_entry <= r_entry;
    else if (i_clear)
      r_entry <= ENTRY_EMPTY;
    else if (i_load)
      r_entry <= i_entry;
  end

  assign o_entry = r_entry;

endmodule

`default_nettype wire

// File: rtl/hazard_forward_unit.sv
// +--------------------------------------------------------------------+
// | hazard_forward_unit: EX operand forwarding, load-use stall, flush. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_reg_write,
  input  logic [4:0]  id_dst,
  input  logic        id_is_load,
  input  logic        ex_redirect,
  input  logic        hold,
  output logic [1:0]  forward_A,
  output logic [1:0]  forward_B,
  output logic        stall_if_id,
  output logic        bubble_id_ex,
  output logic        flush_if_id,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);

  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  entry_t w_id_entry;
  entry_t w_ex;
  entry_t w_mem;
  entry_t w_wb;
  logic   w_load_use;
  logic   w_ls_stall;

  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_comb begin
    w_id_entry           = ENTRY_EMPTY;
    w_id_entry.valid     = id_valid;
    w_id_entry.reg_write = id_reg_write;
    w_id_entry.is_load   = id_is_load;
    w_id_entry.dst       = id_dst;
    w_id_entry.rs        = id_rs;
    w_id_entry.rt        = id_rt;
    w_id_entry.uses_rs   = id_uses_rs;
    w_id_entry.uses_rt   = id_uses_rt;
  end

  hazard_track_entry u_ex (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (hold),
    .i_clear (bubble_id_ex),
    .i_load  (1'b1),
    .i_entry (w_id_entry),
    .o_entry (w_ex)
  );

  hazard_track_entry u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (hold),
    .i_clear (1'b0),
    .i_load  (1'b1),
    .i_entry (w_ex),
    .o_entry (w_mem)
  );

  hazard_track_entry u_wb (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (hold),
    .i_clear (1'b0),
    .i_load  (1'b1),
    .i_entry (w_mem),
    .o_entry (w_wb)
  );

  assign forward_A = fwd_sel(w_mem, w_wb, w_ex.rs, w_ex.uses_rs);
  assign forward_B = fwd_sel(w_mem, w_wb, w_ex.rt, w_ex.uses_rt);

  // Only a load still in EX hazards; once in MEM its data forwards from WB later.
  assign w_load_use = w_ex.valid && w_ex.is_load && w_ex.reg_write &&
                      (w_ex.dst != REG_0_ADDR) && id_valid &&
                      (((w_ex.dst == id_rs) && id_uses_rs) ||
                       ((w_ex.dst == id_rt) && id_uses_rt));

  assign w_ls_stall   = w_load_use && !ex_redirect;
  assign stall_if_id  = hold || w_ls_stall;
  assign bubble_id_ex = w_load_use || ex_redirect;
  assign flush_if_id  = ex_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else if (!hold) begin
      if (w_ls_stall && (r_stall_cycles != C_CNT_MAX))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (ex_redirect && (r_flush_cycles != C_CNT_MAX))
        r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
// +--------------------------------------------------------------------+
// | tb_hazard_forward_unit: directed self-checking bench.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_uses_rs, id_uses_rt, id_reg_write, id_is_load;
  logic        ex_redirect, hold;
  logic [1:0]  forward_A, forward_B;
  logic        stall_if_id, bubble_id_ex, flush_if_id;
  logic [31:0] stall_cycles, flush_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_reg_write (id_reg_write),
    .id_dst       (id_dst),
    .id_is_load   (id_is_load),
    .ex_redirect  (ex_redirect),
    .hold         (hold),
    .forward_A    (forward_A),
    .forward_B    (forward_B),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .flush_if_id  (flush_if_id),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );

  // Advance one edge; inputs change 1 ns after it and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic rw,
                        input logic [4:0] dst, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_dst = dst; id_is_load = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b0; ex_redirect = 1'b0; nop();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    hold = 1'b1; ex_redirect = 1'b0; rst = 1'b1;
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1);
    step();
    rst = 1'b0; hold = 1'b0; nop();
    settle();
    n_checks++; if (forward_A !== 2'b00) $display("FAIL reset_fwdA got %b exp 00", forward_A); else n_pass++;
    n_checks++; if (forward_B !== 2'b00) $display("FAIL reset_fwdB got %b exp 00", forward_B); else n_pass++;
    n_checks++; if (stall_if_id !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall_if_id); else n_pass++;
    n_checks++; if (bubble_id_ex !== 1'b0) $display("FAIL reset_bubble got %b exp 0", bubble_id_ex); else n_pass++;
    n_checks++; if (flush_if_id !== 1'b0) $display("FAIL reset_flush got %b exp 0", flush_if_id); else n_pass++;
    n_checks++; if (stall_cycles !== 32'd0) $display("FAIL reset_stall_cnt got %0d exp 0", stall_cycles); else n_pass++;
    n_checks++; if (flush_cycles !== 32'd0) $display("FAIL reset_flush_cnt got %0d exp 0", flush_cycles); else n_pass++;
  endtask

  task automatic test_forward_mem();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);   // ADD r3,r1,r2
    step();
    set_id(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);   // SUB r8,r3,r7
    step();
    nop();
    settle();
    n_checks++; if (forward_A !== 2'b10) $display("FAIL mem_fwdA got %b exp 10", forward_A); else n_pass++;
    n_checks++; if (forward_B !== 2'b00) $display("FAIL mem_fwdB got %b exp 00", forward_B); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);   // LW r5,0(r1)
    step();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);   // ADD r6,r5,r5
    settle();
    n_checks++; if (stall_if_id !== 1'b1) $display("FAIL lu_stall got %b exp 1", stall_if_id); else n_pass++;
    n_checks++; if (bubble_id_ex !== 1'b1) $display("FAIL lu_bubble got %b exp 1", bubble_id_ex); else n_pass++;
    n_checks++; if (flush_if_id !== 1'b0) $display("FAIL lu_flush got %b exp 0", flush_if_id); else n_pass++;
    step();
    settle();
    n_checks++; if (stall_if_id !== 1'b0) $display("FAIL lu_load_in_mem_stall got %b exp 0", stall_if_id); else n_pass++;
    n_checks++; if (bubble_id_ex !== 1'b0) $display("FAIL lu_load_in_mem_bubble got %b exp 0", bubble_id_ex); else n_pass++;
    step();
    nop();
    settle();
    n_checks++; if (forward_A !== 2'b01) $display("FAIL lu_fwdA got %b exp 01", forward_A); else n_pass++;
    n_checks++; if (forward_B !== 2'b01) $display("FAIL lu_fwdB got %b exp 01", forward_B); else n_pass++;
    n_checks++; if (stall_cycles !== 32'd1) $display("FAIL lu_stall_cnt got %0d exp 1", stall_cycles); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); // ADD r4
      step();
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0); // OR r4
      step();
      if (pass == 1) begin
        nop();
        step();
      end
      set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0); // reader r4, rt=r0
      step();
      nop();
      settle();
      if (pass == 0) begin
        n_checks++; if (forward_A !== 2'b10) $display("FAIL b2b_young_fwdA got %b exp 10", forward_A); else n_pass++;
      end else begin
        n_checks++; if (forward_A !== 2'b01) $display("FAIL b2b_bubble_fwdA got %b exp 01", forward_A); else n_pass++;
      end
      n_checks++; if (forward_B !== 2'b00) $display("FAIL b2b_r0_fwdB got %b exp 00", forward_B); else n_pass++;
    end
  endtask

  task automatic test_reg0();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);   // LW r0
    step();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0);   // reader of r0
    settle();
    n_checks++; if (stall_if_id !== 1'b0) $display("FAIL r0_stall got %b exp 0", stall_if_id); else n_pass++;
    n_checks++; if (bubble_id_ex !== 1'b0) $display("FAIL r0_bubble got %b exp 0", bubble_id_ex); else n_pass++;
    step();
    nop();
    settle();
    n_checks++; if (forward_A !== 2'b00) $display("FAIL r0_fwdA got %b exp 00", forward_A); else n_pass++;
    n_checks++; if (forward_B !== 2'b00) $display("FAIL r0_fwdB got %b exp 00", forward_B); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);   // LW r5
    step();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    ex_redirect = 1'b1;
    settle();
    n_checks++; if (flush_if_id !== 1'b1) $display("FAIL redir_flush got %b exp 1", flush_if_id); else n_pass++;
    n_checks++; if (bubble_id_ex !== 1'b1) $display("FAIL redir_bubble got %b exp 1", bubble_id_ex); else n_pass++;
    n_checks++; if (stall_if_id !== 1'b0) $display("FAIL redir_stall got %b exp 0", stall_if_id); else n_pass++;
    step();
    ex_redirect = 1'b0; nop();
    settle();
    n_checks++; if (flush_cycles !== 32'd1) $display("FAIL redir_flush_cnt got %0d exp 1", flush_cycles); else n_pass++;
    n_checks++; if (stall_cycles !== 32'd0) $display("FAIL redir_stall_cnt got %0d exp 0", stall_cycles); else n_pass++;
  endtask

  task automatic test_hold_and_reset();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);   // ADD r3
    step();
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);   // SUB r8,r3,r3
    step();
    nop();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (forward_A !== 2'b10) $display("FAIL hold%0d_fwdA got %b exp 10", i, forward_A); else n_pass++;
      n_checks++; if (forward_B !== 2'b10) $display("FAIL hold%0d_fwdB got %b exp 10", i, forward_B); else n_pass++;
      n_checks++; if (stall_if_id !== 1'b1) $display("FAIL hold%0d_stall got %b exp 1", i, stall_if_id); else n_pass++;
    end
    hold = 1'b0;
    step();
    settle();
    n_checks++; if (forward_A !== 2'b00) $display("FAIL post_hold_fwdA got %b exp 00", forward_A); else n_pass++;
    // Load-use stall, then reset while it is pending.
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    step();
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    settle();
    n_checks++; if (stall_if_id !== 1'b1) $display("FAIL pre_rst_stall got %b exp 1", stall_if_id); else n_pass++;
    rst = 1'b1; hold = 1'b1; ex_redirect = 1'b1;
    step();
    rst = 1'b0; hold = 1'b0; ex_redirect = 1'b0;
    settle();
    n_checks++; if (stall_if_id !== 1'b0) $display("FAIL rst_mid_stall got %b exp 0", stall_if_id); else n_pass++;
    n_checks++; if (bubble_id_ex !== 1'b0) $display("FAIL rst_mid_bubble got %b exp 0", bubble_id_ex); else n_pass++;
    n_checks++; if (flush_cycles !== 32'd0) $display("FAIL rst_mid_flush_cnt got %0d exp 0", flush_cycles); else n_pass++;
    n_checks++; if (stall_cycles !== 32'd0) $display("FAIL rst_mid_stall_cnt got %0d exp 0", stall_cycles); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forward_mem();
    test_load_use();
    test_back_to_back();
    test_reg0();
    test_redirect();
    test_hold_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
